// File: rtl/axi_lat_delayer.sv
// AXI latency injector: every beat on each of the five AXI channels waits in an
// in-order buffer for a programmable number of cycles before it is presented.

package axi_lat_delayer_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
    } aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } axi_rsp_t;
endpackage

module axi_lat_delayer_chan #(
    parameter type chan_t     = logic,
    parameter int  DelayWidth = 8,
    parameter int  Depth      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DelayWidth-1:0] delay,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  chan_t                 push_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output chan_t                 pop_data,
    output logic                  occupied
);
    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntWidth = $clog2(Depth + 1);

    chan_t                 data_q  [Depth];
    logic [DelayWidth-1:0] count_q [Depth];
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [CntWidth-1:0]   used;
    logic [DelayWidth-1:0] load_count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    function automatic logic [PtrWidth-1:0] advance(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
    endfunction

    assign full       = (used == CntWidth'(Depth));
    assign empty      = (used == '0);
    assign push_ready = rst_n && !full;
    assign pop_valid  = rst_n && !empty && (count_q[rd_ptr] == '0);
    assign pop_data   = data_q[rd_ptr];
    assign occupied   = !empty;
    assign push       = push_valid && push_ready;
    assign pop        = pop_valid && pop_ready;
    // A zero delay still costs one register stage; there is no bypass path.
    assign load_count = (delay == '0) ? '0 : delay - DelayWidth'(1);

    // Free slots always hold a zero countdown (they are reset to zero and only
    // popped at zero), so ticking every nonzero slot only ever ages live beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
            for (int i = 0; i < Depth; i++) begin
                data_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (count_q[i] != '0) begin
                    count_q[i] <= count_q[i] - DelayWidth'(1);
                end
            end
            if (push) begin
                data_q[wr_ptr]  <= push_data;
                count_q[wr_ptr] <= load_count;
                wr_ptr          <= advance(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= advance(rd_ptr);
            end
            if (push && !pop) begin
                used <= used + CntWidth'(1);
            end else if (pop && !push) begin
                used <= used - CntWidth'(1);
            end
        end
    end
endmodule

module axi_lat_delayer #(
    parameter type aw_chan_t  = axi_lat_delayer_pkg::aw_chan_t,
    parameter type w_chan_t   = axi_lat_delayer_pkg::w_chan_t,
    parameter type b_chan_t   = axi_lat_delayer_pkg::b_chan_t,
    parameter type ar_chan_t  = axi_lat_delayer_pkg::ar_chan_t,
    parameter type r_chan_t   = axi_lat_delayer_pkg::r_chan_t,
    parameter type axi_req_t  = axi_lat_delayer_pkg::axi_req_t,
    parameter type axi_rsp_t  = axi_lat_delayer_pkg::axi_rsp_t,
    parameter int  DelayWidth = 8,
    parameter int  Depth      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DelayWidth-1:0] req_delay_i,
    input  logic [DelayWidth-1:0] rsp_delay_i,
    input  axi_req_t              slv_req_i,
    output axi_rsp_t              slv_resp_o,
    output axi_req_t              mst_req_o,
    input  axi_rsp_t              mst_resp_i,
    output logic                  busy_o
);
`ifndef SYNTHESIS
    if (Depth < 1) begin : g_bad_depth
        $fatal(1, "axi_lat_delayer: Depth must be at least 1");
    end
    if (DelayWidth < 1) begin : g_bad_width
        $fatal(1, "axi_lat_delayer: DelayWidth must be at least 1");
    end
`endif

    aw_chan_t aw_data;
    w_chan_t  w_data;
    b_chan_t  b_data;
    ar_chan_t ar_data;
    r_chan_t  r_data;
    logic aw_in_ready, w_in_ready, b_in_ready, ar_in_ready, r_in_ready;
    logic aw_out_valid, w_out_valid, b_out_valid, ar_out_valid, r_out_valid;
    logic aw_busy, w_busy, b_busy, ar_busy, r_busy;

    axi_lat_delayer_chan #(.chan_t(aw_chan_t), .DelayWidth(DelayWidth), .Depth(Depth)) u_aw (
        .clk(clk_i), .rst_n(rst_ni), .delay(req_delay_i),
        .push_valid(slv_req_i.aw_valid), .push_ready(aw_in_ready), .push_data(slv_req_i.aw),
        .pop_valid(aw_out_valid), .pop_ready(mst_resp_i.aw_ready), .pop_data(aw_data),
        .occupied(aw_busy)
    );

    axi_lat_delayer_chan #(.chan_t(w_chan_t), .DelayWidth(DelayWidth), .Depth(Depth)) u_w (
        .clk(clk_i), .rst_n(rst_ni), .delay(req_delay_i),
        .push_valid(slv_req_i.w_valid), .push_ready(w_in_ready), .push_data(slv_req_i.w),
        .pop_valid(w_out_valid), .pop_ready(mst_resp_i.w_ready), .pop_data(w_data),
        .occupied(w_busy)
    );

    axi_lat_delayer_chan #(.chan_t(ar_chan_t), .DelayWidth(DelayWidth), .Depth(Depth)) u_ar (
        .clk(clk_i), .rst_n(rst_ni), .delay(req_delay_i),
        .push_valid(slv_req_i.ar_valid), .push_ready(ar_in_ready), .push_data(slv_req_i.ar),
        .pop_valid(ar_out_valid), .pop_ready(mst_resp_i.ar_ready), .pop_data(ar_data),
        .occupied(ar_busy)
    );

    axi_lat_delayer_chan #(.chan_t(b_chan_t), .DelayWidth(DelayWidth), .Depth(Depth)) u_b (
        .clk(clk_i), .rst_n(rst_ni), .delay(rsp_delay_i),
        .push_valid(mst_resp_i.b_valid), .push_ready(b_in_ready), .push_data(mst_resp_i.b),
        .pop_valid(b_out_valid), .pop_ready(slv_req_i.b_ready), .pop_data(b_data),
        .occupied(b_busy)
    );

    axi_lat_delayer_chan #(.chan_t(r_chan_t), .DelayWidth(DelayWidth), .Depth(Depth)) u_r (
        .clk(clk_i), .rst_n(rst_ni), .delay(rsp_delay_i),
        .push_valid(mst_resp_i.r_valid), .push_ready(r_in_ready), .push_data(mst_resp_i.r),
        .pop_valid(r_out_valid), .pop_ready(slv_req_i.r_ready), .pop_data(r_data),
        .occupied(r_busy)
    );

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_in_ready;
        slv_resp_o.w_ready  = w_in_ready;
        slv_resp_o.ar_ready = ar_in_ready;
        slv_resp_o.b_valid  = b_out_valid;
        slv_resp_o.b        = b_data;
        slv_resp_o.r_valid  = r_out_valid;
        slv_resp_o.r        = r_data;

        mst_req_o           = '0;
        mst_req_o.aw_valid  = aw_out_valid;
        mst_req_o.aw        = aw_data;
        mst_req_o.w_valid   = w_out_valid;
        mst_req_o.w         = w_data;
        mst_req_o.ar_valid  = ar_out_valid;
        mst_req_o.ar        = ar_data;
        mst_req_o.b_ready   = b_in_ready;
        mst_req_o.r_ready   = r_in_ready;
    end

    assign busy_o = rst_ni && (aw_busy || w_busy || ar_busy || b_busy || r_busy);
endmodule

// File: tb/tb_axi_lat_delayer.sv
// Directed bench for axi_lat_delayer: drivers push expected beats into
// per-channel queues, a negedge monitor pops and compares on every handshake.

module tb_axi_lat_delayer;
    import axi_lat_delayer_pkg::*;

    localparam int DelayWidth = 8;
    localparam int Depth      = 4;
    localparam int CH_AW = 0, CH_W = 1, CH_B = 2, CH_AR = 3, CH_R = 4;

    typedef struct {
        logic [63:0] data;
        int          when;
        bit          exact;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic [DelayWidth-1:0] req_delay;
    logic [DelayWidth-1:0] rsp_delay;
    axi_req_t              slv_req;
    axi_rsp_t              slv_resp;
    axi_req_t              mst_req;
    axi_rsp_t              mst_resp;
    logic                  busy;

    int   cyc = 0;
    int   compared = 0;
    int   failed = 0;
    exp_t q_aw[$], q_w[$], q_b[$], q_ar[$], q_r[$];

    axi_lat_delayer #(.DelayWidth(DelayWidth), .Depth(Depth)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_delay_i (req_delay),
        .rsp_delay_i (rsp_delay),
        .slv_req_i   (slv_req),
        .slv_resp_o  (slv_resp),
        .mst_req_o   (mst_req),
        .mst_resp_i  (mst_resp),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [10:0] outputs_vec();
        return {slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready, slv_resp.b_valid,
                slv_resp.r_valid, mst_req.aw_valid, mst_req.w_valid, mst_req.ar_valid,
                mst_req.b_ready, mst_req.r_ready, busy};
    endfunction

    function automatic int pending();
        return q_aw.size() + q_w.size() + q_b.size() + q_ar.size() + q_r.size();
    endfunction

    function automatic logic get_ready(input int ch);
        case (ch)
            CH_AW:   return slv_resp.aw_ready;
            CH_W:    return slv_resp.w_ready;
            CH_B:    return mst_req.b_ready;
            CH_AR:   return slv_resp.ar_ready;
            default: return mst_req.r_ready;
        endcase
    endfunction

    task automatic set_valid(input int ch, input logic v, input logic [63:0] d);
        case (ch)
            CH_AW: begin slv_req.aw_valid = v;  slv_req.aw = aw_chan_t'(d[$bits(aw_chan_t)-1:0]); end
            CH_W:  begin slv_req.w_valid = v;   slv_req.w = w_chan_t'(d[$bits(w_chan_t)-1:0]); end
            CH_B:  begin mst_resp.b_valid = v;  mst_resp.b = b_chan_t'(d[$bits(b_chan_t)-1:0]); end
            CH_AR: begin slv_req.ar_valid = v;  slv_req.ar = ar_chan_t'(d[$bits(ar_chan_t)-1:0]); end
            default: begin mst_resp.r_valid = v; mst_resp.r = r_chan_t'(d[$bits(r_chan_t)-1:0]); end
        endcase
    endtask

    task automatic push_exp(input int ch, input logic [63:0] d, input int when, input bit exact);
        exp_t e;
        e.data  = d;
        e.when  = when;
        e.exact = exact;
        case (ch)
            CH_AW:   q_aw.push_back(e);
            CH_W:    q_w.push_back(e);
            CH_B:    q_b.push_back(e);
            CH_AR:   q_ar.push_back(e);
            default: q_r.push_back(e);
        endcase
    endtask

    // Called just after a rising edge; lat < 0 means the beat is not expected out.
    task automatic send(input int ch, input logic [63:0] d, input int lat, input bit exact,
                        output int t);
        int guard;
        bit acc;
        guard = 0;
        acc   = 0;
        t     = -1;
        set_valid(ch, 1'b1, d);
        while (!acc && guard < 200) begin
            @(negedge clk);
            if (get_ready(ch)) begin
                acc = 1;
                t   = cyc;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        set_valid(ch, 1'b0, d);
        if (!acc) begin
            compared++;
            failed++;
            $display("[TB] FAIL accept_timeout ch%0d: got no ready, required accept within 200 cycles", ch);
        end else if (lat >= 0) begin
            push_exp(ch, d, t + lat, exact);
        end
    endtask

    task automatic check_output(input int ch, input string name, input logic [63:0] act, input int now);
        exp_t e;
        bit   have;
        have = 0;
        case (ch)
            CH_AW:   if (q_aw.size() > 0) begin e = q_aw.pop_front(); have = 1; end
            CH_W:    if (q_w.size() > 0)  begin e = q_w.pop_front();  have = 1; end
            CH_B:    if (q_b.size() > 0)  begin e = q_b.pop_front();  have = 1; end
            CH_AR:   if (q_ar.size() > 0) begin e = q_ar.pop_front(); have = 1; end
            default: if (q_r.size() > 0)  begin e = q_r.pop_front();  have = 1; end
        endcase
        compared++;
        if (!have) begin
            failed++;
            $display("[TB] FAIL %s_unexpected: got beat %0h at cycle %0d, required none", name, act, now);
        end else if (act !== e.data) begin
            failed++;
            $display("[TB] FAIL %s_payload: got %0h, required %0h", name, act, e.data);
        end else if (e.exact ? (now != e.when) : (now < e.when)) begin
            failed++;
            $display("[TB] FAIL %s_timing: got cycle %0d, required %s%0d", name, now,
                     e.exact ? "" : ">=", e.when);
        end
    endtask

    always @(negedge clk) begin
        if (mst_req.aw_valid && mst_resp.aw_ready) check_output(CH_AW, "aw", 64'(mst_req.aw), cyc);
        if (mst_req.w_valid && mst_resp.w_ready)   check_output(CH_W, "w", 64'(mst_req.w), cyc);
        if (mst_req.ar_valid && mst_resp.ar_ready) check_output(CH_AR, "ar", 64'(mst_req.ar), cyc);
        if (slv_resp.b_valid && slv_req.b_ready)   check_output(CH_B, "b", 64'(slv_resp.b), cyc);
        if (slv_resp.r_valid && slv_req.r_ready)   check_output(CH_R, "r", 64'(slv_resp.r), cyc);
    end

    // Returns just after a rising edge so the next send is aligned.
    task automatic drain();
        int guard;
        guard = 0;
        while (pending() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (pending() != 0) begin
            compared++;
            failed++;
            $display("[TB] FAIL drain_timeout: got %0d beats outstanding, required 0", pending());
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t, t_first, t_last, t_ar, t_aw, t_w, t_b;
        slv_req           = '0;
        mst_resp          = '0;
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.ar_ready = 1'b1;
        slv_req.b_ready   = 1'b1;
        slv_req.r_ready   = 1'b1;
        req_delay         = '0;
        rsp_delay         = '0;
        rst_n             = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'(outputs_vec()), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_readies", 64'({slv_resp.aw_ready, slv_resp.w_ready, slv_resp.ar_ready,
                                   mst_req.b_ready, mst_req.r_ready}), 64'h1f);
        check("idle_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Fixed latency of 5 on AR.
        req_delay = 8'd5;
        send(CH_AR, 64'h3_1234_5678, 5, 1, t);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("ar_busy_window", 64'(busy), 64'd1);
        end
        @(negedge clk);
        check("ar_valid_dropped", 64'(mst_req.ar_valid), 64'd0);
        check("ar_busy_clear", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Zero delay behaves as one cycle; full throughput on R.
        rsp_delay = 8'd0;
        t_first = 0;
        t_last  = 0;
        for (int i = 0; i < 8; i++) begin
            send(CH_R, 64'h10 + 64'(i), 1, 1, t);
            if (i == 0) t_first = t;
            t_last = t;
        end
        check("r_back_to_back", 64'(t_last - t_first), 64'd7);
        drain();

        // W backpressure: four fill the buffer, head stays stable while stalled.
        req_delay        = 8'd2;
        mst_resp.w_ready = 1'b0;
        fork
            for (int i = 0; i < 6; i++) send(CH_W, 64'h1_0000_0A00 + 64'(i), 2, 0, t);
            begin
                repeat (12) @(negedge clk);
                check("w_full_ready", 64'(slv_resp.w_ready), 64'd0);
                check("w_stall_valid", 64'(mst_req.w_valid), 64'd1);
                check("w_stall_payload", 64'(mst_req.w), 64'h1_0000_0A00);
                repeat (7) @(negedge clk);
                check("w_stall_valid_late", 64'(mst_req.w_valid), 64'd1);
                check("w_stall_payload_late", 64'(mst_req.w), 64'h1_0000_0A00);
                @(posedge clk);
                #1 mst_resp.w_ready = 1'b1;
            end
        join
        drain();

        // Delay change mid-stream: AW#2 waits behind AW#1, AW#3 sees the new delay.
        req_delay = 8'd10;
        send(CH_AW, 64'h1_AAAA_0001, 10, 1, t);
        req_delay = 8'd1;
        send(CH_AW, 64'h2_AAAA_0002, 10, 1, t);
        drain();
        send(CH_AW, 64'h3_AAAA_0003, 1, 1, t);
        drain();

        // Reset with three B beats in flight discards them.
        rsp_delay = 8'd8;
        for (int i = 1; i <= 3; i++) send(CH_B, 64'h20 + 64'(i), -1, 0, t);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_outputs", 64'(outputs_vec()), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("reset_mid_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rsp_delay = 8'd3;
        send(CH_B, 64'h2A, 3, 1, t);
        drain();

        // R stalled and full while the other channels keep exact latency.
        slv_req.r_ready = 1'b0;
        rsp_delay       = 8'd1;
        for (int i = 0; i < 4; i++) send(CH_R, 64'h40 + 64'(i), 1, 0, t);
        @(negedge clk);
        check("r_full_ready", 64'(mst_req.r_ready), 64'd0);
        @(posedge clk);
        #1;
        req_delay = 8'd3;
        rsp_delay = 8'd2;
        fork
            send(CH_AR, 64'h5_0000_0055, 3, 1, t_ar);
            send(CH_AW, 64'h6_0000_0066, 3, 1, t_aw);
            send(CH_W, 64'h0_0000_0077, 3, 1, t_w);
            send(CH_B, 64'h1B, 2, 1, t_b);
        join
        repeat (6) @(negedge clk);
        check("side_channels_done", 64'(q_aw.size() + q_w.size() + q_ar.size() + q_b.size()), 64'd0);
        check("r_still_stalled", 64'(slv_resp.r_valid), 64'd1);
        @(posedge clk);
        #1 slv_req.r_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
